// File: rtl/router_sync_controller_pkg.sv
// Shared types and default sizes for the router sync controller.
package router_ctrl_pkg;

  localparam int TILE_W_DEF    = 8;
  localparam int ROW_COUNT_DEF = 4;
  localparam int TIMEOUT_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SYNC,
    STREAM,
    NEXT,
    DONE
  } sync_state_e;

endpackage

// File: rtl/router_sync_controller_done_latch.sv
// Sticky completion flag for one router; clear wins over set.
module done_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clear_i,
  output logic flag_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clear_i) begin
      flag_d = 1'b0;
    end else if (set_i) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/router_sync_controller.sv
// Sequences tiles across the input and weight routers and pops both in lockstep.
// Define ROUTER_SYNC_WATCHDOG_EN to add the SYNC-state watchdog and sticky o_error.
module router_sync_controller
  import router_ctrl_pkg::*;
#(
  parameter int TILE_W    = TILE_W_DEF,
  parameter int ROW_COUNT = ROW_COUNT_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_start,
  input  logic                 i_reg_clear,
  input  logic [TILE_W-1:0]    i_tile_count,
  input  logic                 i_ir_ready,
  input  logic                 i_wr_ready,
  input  logic                 i_ir_route_done,
  input  logic                 i_wr_route_done,
  input  logic                 i_ir_rerouting,
  input  logic                 i_array_ready,
  output logic                 o_ir_en,
  output logic                 o_wr_en,
  output logic                 o_reg_clear,
  output logic                 o_data_out_en,
  output logic [ROW_COUNT-1:0] o_row_mask,
  output logic [TILE_W-1:0]    o_tile_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  sync_state_e       state_q, state_d;
  logic [TILE_W-1:0] count_q, count_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic              ir_done, wr_done;
  logic              routing, router_ok, all_ready, wd_fire;

  assign routing   = (state_q == SYNC) || (state_q == STREAM);
  assign router_ok = i_ir_ready & i_wr_ready & ~i_ir_rerouting;
  assign all_ready = router_ok & i_array_ready;

  done_latch u_ir_done (
    .clk_i  (i_clk),
    .rst_ni (i_nrst),
    .set_i  (i_ir_route_done & routing),
    .clear_i(state_q == CLEAR),
    .flag_o (ir_done)
  );

  done_latch u_wr_done (
    .clk_i  (i_clk),
    .rst_ni (i_nrst),
    .set_i  (i_wr_route_done & routing),
    .clear_i(state_q == CLEAR),
    .flag_o (wr_done)
  );

`ifdef ROUTER_SYNC_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 err_q, err_d;

  // Counter restarts every time SYNC is entered; it never wraps because firing leaves SYNC.
  assign wd_d    = (state_q == SYNC) ? wd_q + TIMEOUT_W'(1) : '0;
  assign wd_fire = (state_q == SYNC) && (wd_q == '1);

  always_comb begin
    err_d = err_q;
    if (!i_reg_clear) begin
      if (wd_fire) begin
        err_d = 1'b1;
      end else if ((state_q == IDLE) && i_start) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign wd_fire = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      count_q <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tile_q  <= tile_d;
    end
  end

  // Abort and watchdog override every normal transition, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tile_d  = tile_q;
    if (i_reg_clear || wd_fire) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            count_d = i_tile_count;
            tile_d  = '0;
            state_d = (i_tile_count == '0) ? DONE : CLEAR;
          end
        end
        CLEAR:  state_d = SYNC;
        SYNC:   if (all_ready) state_d = STREAM;
        STREAM: begin
          if (ir_done && wr_done) begin
            state_d = NEXT;
          end else if (!router_ok) begin
            state_d = SYNC;
          end
        end
        NEXT: begin
          if (tile_q == count_q - TILE_W'(1)) begin
            state_d = DONE;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = CLEAR;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_reg_clear   = (state_q == CLEAR) | i_reg_clear | wd_fire;
    o_ir_en       = routing;
    o_wr_en       = routing;
    o_data_out_en = (state_q == STREAM) & all_ready;
    o_busy        = (state_q != IDLE);
    o_done        = (state_q == DONE);
  end

  assign o_row_mask = {ROW_COUNT{o_data_out_en}};
  assign o_tile_idx = tile_q;

endmodule
